// File: rtl/vga_pkg.sv
// Shared VGA constants: pattern selects, colour-bar table, default timing.
// Common to the sync generator and the pixel generator.
package vga_pkg;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_CHECK = 2'd1;
  localparam logic [1:0] PAT_RAMP  = 2'd2;
  localparam logic [1:0] PAT_SOLID = 2'd3;

  // One bit per channel {r,g,b}: 1 = full, 0 = zero. Index 0 is the left bar.
  localparam logic [7:0][2:0] BAR_RGB = {
    3'b000, 3'b001, 3'b100, 3'b101,
    3'b010, 3'b011, 3'b110, 3'b111
  };

  localparam int H_ACTIVE_DEF    = 640;
  localparam int V_ACTIVE_DEF    = 480;
  localparam int LEFT_BORDER_DEF = 47;
  localparam int TOP_BORDER_DEF  = 32;
  localparam int H_WIDTH_DEF     = 10;
  localparam int V_WIDTH_DEF     = 10;

endpackage

// File: rtl/bounce_box.sv
// Bouncing overlay box: position/direction state and inside test.
// Position steps one pixel per axis on each frame boundary.
module bounce_box #(
  parameter int H_WIDTH  = 10,
  parameter int V_WIDTH  = 10,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BOX_SIZE = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step_i,
  input  logic [H_WIDTH-1:0] x_i,
  input  logic [V_WIDTH-1:0] y_i,
  output logic               inside_o
);

  localparam logic [H_WIDTH-1:0] H_LIM = H_WIDTH'(H_ACTIVE - BOX_SIZE);
  localparam logic [V_WIDTH-1:0] V_LIM = V_WIDTH'(V_ACTIVE - BOX_SIZE);
  localparam logic [H_WIDTH-1:0] H_ONE = H_WIDTH'(1);
  localparam logic [V_WIDTH-1:0] V_ONE = V_WIDTH'(1);

  logic [H_WIDTH-1:0] bx_q, bx_d;
  logic [V_WIDTH-1:0] by_q, by_d;
  logic               dx_q, dx_d;
  logic               dy_q, dy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bx_q <= '0;
      by_q <= '0;
      dx_q <= 1'b1;
      dy_q <= 1'b1;
    end else begin
      bx_q <= bx_d;
      by_q <= by_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  // A flip takes effect immediately: the same frame moves the other way.
  always_comb begin
    bx_d = bx_q;
    dx_d = dx_q;
    by_d = by_q;
    dy_d = dy_q;
    if (step_i) begin
      if (dx_q) begin
        if (bx_q == H_LIM) begin
          dx_d = 1'b0;
          bx_d = bx_q - H_ONE;
        end else begin
          bx_d = bx_q + H_ONE;
        end
      end else if (bx_q == '0) begin
        dx_d = 1'b1;
        bx_d = H_ONE;
      end else begin
        bx_d = bx_q - H_ONE;
      end
      if (dy_q) begin
        if (by_q == V_LIM) begin
          dy_d = 1'b0;
          by_d = by_q - V_ONE;
        end else begin
          by_d = by_q + V_ONE;
        end
      end else if (by_q == '0) begin
        dy_d = 1'b1;
        by_d = V_ONE;
      end else begin
        by_d = by_q - V_ONE;
      end
    end
  end

  logic [H_WIDTH:0] bx_end;
  logic [V_WIDTH:0] by_end;

  assign bx_end = {1'b0, bx_q} + (H_WIDTH+1)'(BOX_SIZE - 1);
  assign by_end = {1'b0, by_q} + (V_WIDTH+1)'(BOX_SIZE - 1);

  assign inside_o = (x_i >= bx_q) && ({1'b0, x_i} <= bx_end) &&
                    (y_i >= by_q) && ({1'b0, y_i} <= by_end);

endmodule

// File: rtl/pixel_generator.sv
// Test-pattern pixel generator, 2-stage pipeline aligned to the sync outputs.
// Define BOUNCE_BOX_EN to add the animated white box overlay.
module pixel_generator
  import vga_pkg::*;
#(
  parameter int H_WIDTH     = 10,
  parameter int V_WIDTH     = 10,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LEFT_BORDER = 47,
  parameter int TOP_BORDER  = 32,
  parameter int COLOR_W     = 4,
  parameter int BOX_SIZE    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [H_WIDTH-1:0]   h_count,
  input  logic [V_WIDTH-1:0]   v_count,
  input  logic                 h_sync,
  input  logic                 v_sync,
  input  logic                 video_on,
  input  logic [1:0]           pattern_sel,
  input  logic [3*COLOR_W-1:0] solid_rgb,
  input  logic                 box_en,
  output logic [COLOR_W-1:0]   vga_r,
  output logic [COLOR_W-1:0]   vga_g,
  output logic [COLOR_W-1:0]   vga_b,
  output logic                 vga_hs,
  output logic                 vga_vs,
  output logic                 frame_tick
);

  localparam int CW = 3 * COLOR_W;
  localparam int BAR_W = H_ACTIVE / 8;
  localparam logic [H_WIDTH-1:0] X_OFF = H_WIDTH'(LEFT_BORDER + 1);
  localparam logic [V_WIDTH-1:0] Y_OFF = V_WIDTH'(TOP_BORDER + 1);
  localparam logic [COLOR_W-1:0] FULL = '1;
  localparam logic [CW-1:0] WHITE = '1;

  logic [H_WIDTH-1:0] x;
  logic [V_WIDTH-1:0] y;
  logic               boundary;
  logic               v_sync_d_q;
  logic [1:0]         pat_q, pat_d;
  logic               tick_q;
  logic [CW-1:0]      col_q, col_d, pat_col;
  logic [CW-1:0]      rgb_q, rgb_d;
  logic               hs_q, vs_q;
  logic [2:0]         bar_bits;
  logic [3:0]         ramp4;
  logic               box_hit;

  assign x = h_count - X_OFF;
  assign y = v_count - Y_OFF;
  assign boundary = v_sync_d_q & ~v_sync;
  assign pat_d = boundary ? pattern_sel : pat_q;
  assign ramp4 = x[9:6];

  // Priority chain: the leftmost bar whose right edge lies beyond x wins.
  always_comb begin
    bar_bits = BAR_RGB[7];
    for (int i = 6; i >= 0; i--) begin
      if (int'(x) < (i + 1) * BAR_W) bar_bits = BAR_RGB[i];
    end
  end

  always_comb begin
    pat_col = '0;
    unique case (pat_q)
      PAT_BARS: pat_col = {bar_bits[2] ? FULL : '0,
                           bar_bits[1] ? FULL : '0,
                           bar_bits[0] ? FULL : '0};
      PAT_CHECK: pat_col = (x[5] ^ y[5]) ? WHITE : '0;
      PAT_RAMP: pat_col = {3{COLOR_W'(ramp4)}};
      PAT_SOLID: pat_col = solid_rgb;
      default: pat_col = '0;
    endcase
  end

`ifdef BOUNCE_BOX_EN
  logic inside;

  bounce_box #(
    .H_WIDTH (H_WIDTH),
    .V_WIDTH (V_WIDTH),
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE),
    .BOX_SIZE(BOX_SIZE)
  ) u_box (
    .clk     (clk),
    .rst_n   (rst_n),
    .step_i  (boundary),
    .x_i     (x),
    .y_i     (y),
    .inside_o(inside)
  );

  assign box_hit = box_en & inside;
`else
  logic unused_box;
  assign unused_box = ^{box_en, y};
  assign box_hit = 1'b0;
`endif

  assign col_d = box_hit ? WHITE : pat_col;
  assign rgb_d = video_on ? col_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_sync_d_q <= 1'b0;
      pat_q      <= PAT_BARS;
      tick_q     <= 1'b0;
      col_q      <= '0;
      rgb_q      <= '0;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
    end else begin
      v_sync_d_q <= v_sync;
      pat_q      <= pat_d;
      tick_q     <= boundary;
      col_q      <= col_d;
      rgb_q      <= rgb_d;
      hs_q       <= h_sync;
      vs_q       <= v_sync;
    end
  end

  assign vga_r      = rgb_q[CW-1 -: COLOR_W];
  assign vga_g      = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign vga_b      = rgb_q[COLOR_W-1:0];
  assign vga_hs     = hs_q;
  assign vga_vs     = vs_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_pixel_generator.sv
// Directed + random bench for pixel_generator against a latency-based model.
// Default build: overlay disabled, box_en held low.
module tb_pixel_generator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  h_count = '0;
  logic [9:0]  v_count = '0;
  logic        h_sync = 1'b0;
  logic        v_sync = 1'b0;
  logic        video_on = 1'b0;
  logic [1:0]  pattern_sel = '0;
  logic [11:0] solid_rgb = '0;
  logic        box_en = 1'b0;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, frame_tick;

  pixel_generator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .h_count    (h_count),
    .v_count    (v_count),
    .h_sync     (h_sync),
    .v_sync     (v_sync),
    .video_on   (video_on),
    .pattern_sel(pattern_sel),
    .solid_rgb  (solid_rgb),
    .box_en     (box_en),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .vga_hs     (vga_hs),
    .vga_vs     (vga_vs),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  localparam int MAXC = 4096;

  int n_assert = 0;
  int n_fail = 0;
  int n = 0;
  logic prev_vs = 1'b0;
  logic [9:0]  hc_h [MAXC];
  logic [9:0]  vc_h [MAXC];
  logic [11:0] sol_h [MAXC];
  logic [1:0]  pat_h [MAXC];

  // Colour the spec assigns to beam position (hc,vc) under a pattern.
  function automatic logic [11:0] ref_colour(input logic [1:0] pat,
      input int hc, input int vc, input logic [11:0] sol);
    int x, y, idx, g;
    logic [11:0] bars [8];
    bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
             12'hF0F, 12'hF00, 12'h00F, 12'h000};
    x = (hc - 48) & 1023;
    y = (vc - 33) & 1023;
    case (pat)
      2'd0: begin
        idx = x / 80;
        return (idx >= 7) ? 12'h000 : bars[idx];
      end
      2'd1: return ((((x / 32) + (y / 32)) % 2) == 1) ? 12'hFFF : 12'h000;
      2'd2: begin
        g = (x / 64) % 16;
        return {g[3:0], g[3:0], g[3:0]};
      end
      default: return sol;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rgb"}, {20'd0, vga_r, vga_g, vga_b}, 32'd0);
    check({tag, "_sync"}, {29'd0, vga_hs, vga_vs, frame_tick}, 32'd0);
  endtask

  // One clock: drive at negedge, check just after the posedge.
  task automatic step(input int hc, input int vc, input logic vo,
      input logic hs, input logic vs, input logic [1:0] sel,
      input logic [11:0] sol);
    logic fall;
    logic [11:0] exp_rgb;
    h_count = hc[9:0];
    v_count = vc[9:0];
    video_on = vo;
    h_sync = hs;
    v_sync = vs;
    pattern_sel = sel;
    solid_rgb = sol;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      check_zero("in_reset");
      n = 0;
      pat_h[0] = 2'd0;
      prev_vs = 1'b0;
    end else begin
      fall = prev_vs & ~vs;
      hc_h[n] = hc[9:0];
      vc_h[n] = vc[9:0];
      sol_h[n] = sol;
      if (n == 0 || !vo) exp_rgb = 12'h000;
      else exp_rgb = ref_colour(pat_h[n-1], int'(hc_h[n-1]),
                                int'(vc_h[n-1]), sol_h[n-1]);
      check("rgb", {20'd0, vga_r, vga_g, vga_b}, {20'd0, exp_rgb});
      check("hs", {31'd0, vga_hs}, {31'd0, hs});
      check("vs", {31'd0, vga_vs}, {31'd0, vs});
      check("frame_tick", {31'd0, frame_tick}, {31'd0, fall});
      if (n < MAXC - 1) begin
        pat_h[n+1] = fall ? sel : pat_h[n];
        n++;
      end
      prev_vs = vs;
    end
    @(negedge clk);
  endtask

  task automatic boundary(input logic [1:0] sel);
    step(0, 0, 1'b0, 1'b0, 1'b1, sel, 12'h000);
    step(0, 0, 1'b0, 1'b0, 1'b0, sel, 12'h000);
  endtask

  task automatic px(input int hc, input int vc, input logic vo,
                    input logic [1:0] sel, input logic [11:0] sol);
    step(hc, vc, vo, 1'b1, 1'b0, sel, sol);
  endtask

  initial begin
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("reset_async");
    repeat (3) step($urandom_range(0, 799), $urandom_range(0, 524),
                    1'b1, 1'b1, 1'b1, 2'($urandom), 12'($urandom));
    rst_n = 1'b1;

    boundary(2'd0);
    px(48, 33, 1'b1, 2'd0, 12'h000);
    px(128, 33, 1'b1, 2'd0, 12'h000);
    px(608, 33, 1'b1, 2'd0, 12'h000);
    px(608, 33, 1'b1, 2'd0, 12'h000);

    boundary(2'd3);
    px(100, 40, 1'b0, 2'd3, 12'hABC);
    px(100, 40, 1'b0, 2'd3, 12'hABC);
    px(100, 40, 1'b1, 2'd3, 12'hABC);
    px(100, 40, 1'b1, 2'd3, 12'hABC);

    boundary(2'd0);
    px(48, 33, 1'b1, 2'd1, 12'h000);
    px(128, 33, 1'b1, 2'd1, 12'h000);
    px(48, 33, 1'b1, 2'd1, 12'h000);
    boundary(2'd1);
    px(80, 33, 1'b1, 2'd1, 12'h000);
    px(80, 65, 1'b1, 2'd1, 12'h000);
    px(80, 65, 1'b1, 2'd1, 12'h000);
    px(80, 65, 1'b1, 2'd1, 12'h000);

    boundary(2'd2);
    px(687, 100, 1'b1, 2'd2, 12'h000);
    px(687, 100, 1'b1, 2'd2, 12'h000);

    repeat (500) step($urandom_range(0, 799), $urandom_range(0, 524),
                      1'($urandom), 1'($urandom),
                      ($urandom_range(0, 3) != 0), 2'($urandom),
                      12'($urandom));

    step(100, 100, 1'b1, 1'b1, 1'b1, 2'd3, 12'h123);
    rst_n = 1'b0;
    #1;
    check_zero("reset_midframe");
    step(100, 100, 1'b1, 1'b1, 1'b1, 2'd3, 12'h123);
    step(100, 100, 1'b1, 1'b1, 1'b1, 2'd3, 12'h123);
    rst_n = 1'b1;
    px(48, 33, 1'b1, 2'd3, 12'h123);
    px(48, 33, 1'b1, 2'd3, 12'h123);
    boundary(2'd1);
    px(80, 33, 1'b1, 2'd1, 12'h000);
    px(80, 33, 1'b1, 2'd1, 12'h000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_generator.md
# pixel_generator

Downstream stage of the VGA sync generator. It consumes the shared `h_count`/`v_count` beam position together with the registered `h_sync`, `v_sync` and `video_on`. It renders a selectable test pattern and drives pipeline-aligned RGB and sync outputs to the DAC/pins. Pattern changes and the optional animated overlay update only at frame boundaries, so no frame tears.

## Interface
- `H_WIDTH`, 10: width of `h_count`.
- `V_WIDTH`, 10: width of `v_count`.
- `H_ACTIVE`, 640: visible pixels per line.
- `V_ACTIVE`, 480: visible lines per frame.
- `LEFT_BORDER`, 47: `h_count` value immediately before the first visible pixel.
- `TOP_BORDER`, 32: `v_count` value immediately before the first visible line.
- `COLOR_W`, 4: bits per colour channel.
- `BOX_SIZE`, 32: overlay box edge, in pixels.
- Clock and reset:
  - `clk`  in  1  pixel clock; single clock domain.
  - `rst_n`  in  1  asynchronous, active-low reset.
- Beam position and sync inputs:
  - `h_count`  in  H_WIDTH  horizontal beam position; same value the sync generator sees this cycle.
  - `v_count`  in  V_WIDTH  vertical beam position.
  - `h_sync`, `v_sync`, `video_on`  in  1 each  registered outputs of the sync generator, one cycle behind the counts.
- Control inputs:
  - `pattern_sel`  in  2  requested pattern.
  - `solid_rgb`  in  3*COLOR_W  colour for solid mode, packed `{r,g,b}`.
  - `box_en`  in  1  enables the overlay (effective only when `BOUNCE_BOX_EN` is defined).
- Outputs:
  - `vga_r`, `vga_g`, `vga_b`  out  COLOR_W each  pixel colour.
  - `vga_hs`, `vga_vs`  out  1 each  delayed syncs.
  - `frame_tick`  out  1  one-cycle pulse at each frame boundary.

## Operation
- Coordinates:
  - `x = h_count - (LEFT_BORDER+1)` and `y = v_count - (TOP_BORDER+1)`, each truncated to its counter width.
  - Out-of-range values are don't-care because the output is blanked by `video_on`.
- Frame boundary: `frame_tick` is asserted in the cycle after a falling edge of `v_sync` is detected, i.e. `v_sync_d==1 && v_sync==0`. The internal `v_sync_d` register resets to 0.
- Pattern register `pat_q` resets to 0 and loads `pattern_sel` only on the frame-boundary condition. Mid-frame changes of `pattern_sel` are ignored until the next boundary.
- Patterns:
  - 0, colour bars: 8 bars of 80 px, selected by a comparator chain on `x`. Order, as `{r,g,b}` full/zero: white, yellow, cyan, green, magenta, red, blue, black. A full channel is all ones.
  - 1, checkerboard: white when `x[5]^y[5]`, else black.
  - 2, grey ramp: all channels equal `x[9:6]`, zero-extended or truncated to COLOR_W.
  - 3, solid: `solid_rgb`.
- Pipeline stage 1 registers the pattern colour from the counts. It aligns with the incoming `video_on`/`h_sync`/`v_sync`.
- Stage 2 registers `rgb = video_on ? colour : 0` and registers `vga_hs = h_sync`, `vga_vs = v_sync`.

## Timing
- Latency: 2 clk from `h_count`/`v_count` to `vga_*`; 1 clk from `h_sync`/`v_sync`/`video_on` to `vga_*`. RGB and syncs stay mutually aligned.
- Reset values:
  - `vga_r`, `vga_g`, `vga_b` = 0.
  - `vga_hs`, `vga_vs` = 0, matching the sync generator's reset level.
  - `frame_tick` = 0.
  - `pat_q` = 0.
  - Box at x=0, y=0, moving +x, +y.
- Reset asserted mid-frame clears all state immediately. After release, no `frame_tick` occurs until a genuine 1→0 transition of `v_sync`.
- A `pattern_sel` change in the same cycle as the boundary is captured.

## Configuration
- `BOUNCE_BOX_EN` defined:
  - A BOX_SIZE square is overlaid in white on any pattern when `box_en`=1.
  - Position `bx`, `by` advances by 1 px per axis on each boundary.
  - Each direction flips when the next step would exceed `H_ACTIVE-BOX_SIZE` (608) or drop below 0. On the frame where it flips, the position moves one step in the new direction, with no stall.
  - Inside test: `x` in [bx, bx+BOX_SIZE-1] and `y` in [by, by+BOX_SIZE-1]. Vertical limit is `V_ACTIVE-BOX_SIZE` (448).
- Not defined: no box logic or registers are synthesised; `box_en` is ignored.

## Structure
- Shared `vga_pkg` holds:
  - the pattern-select localparams (`PAT_BARS`, `PAT_CHECK`, `PAT_RAMP`, `PAT_SOLID`);
  - the 8-entry colour-bar `{r,g,b}` constants;
  - default timing constants common with the sync generator.
- One sub-module, `bounce_box`: position/direction registers and the inside-box comparator. It is instantiated only under `BOUNCE_BOX_EN`.

## Test plan
- Reset: hold `rst_n`=0 with arbitrary inputs → all outputs 0; release → `vga_*` track inputs with the stated latency.
- Colour bars:
  - `pattern_sel`=0, then one frame boundary. `h_count`=48, `v_count`=33 with matching `video_on`=1 → two cycles later RGB = (F,F,F).
  - `h_count`=48+80 → yellow (F,F,0).
  - `h_count`=48+560 → black.
- Blanking: `video_on`=0 with `pattern_sel`=3, `solid_rgb`=12'hABC → RGB=0. With `video_on`=1 → RGB = A,B,C.
- Pattern latch: change `pattern_sel` from 0 to 1 mid-frame → bars persist until the `v_sync` falling edge, then checkerboard. `frame_tick` is high for exactly 1 cycle.
- Checker/ramp:
  - `x`=32, `y`=0 in mode 1 → white; `x`=32, `y`=32 → black.
  - Mode 2, `x`=640-1 → all channels = 9.
- Box (`BOUNCE_BOX_EN`, `box_en`=1):
  - After 608 boundaries, `bx`=608.
  - After the next boundary, `bx`=607.
  - Pixel (0,0) is white after reset and before the first boundary.
